// File: rtl/sy_fifo_if.sv
// sy_fifo_if: write/read handshake and status bundle for sy_fifo.
interface sy_fifo_if #(parameter int WIDTH = 8);
  logic wr_en, rd_en, full, empty, wr_err, rd_err;
  logic [WIDTH-1:0] w_data, r_data;
  modport master (output wr_en, rd_en, w_data, input r_data, full, empty, wr_err, rd_err);
  modport slave (input wr_en, rd_en, w_data, output r_data, full, empty, wr_err, rd_err);
endinterface

// File: rtl/sy_fifo.sv
// sy_fifo: single-clock FIFO with full/empty flags and overflow/underflow pulses.
// Define SYFIFO_COUNT_EN to expose the internal occupancy as fill_count.
module sy_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int ADDR_PTR_WIDTH = 4
) (
  input logic clk,
  input logic rst,
  sy_fifo_if.slave bus
`ifdef SYFIFO_COUNT_EN
  ,
  output logic [ADDR_PTR_WIDTH:0] fill_count
`endif
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR_PTR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_PTR_WIDTH:0] count;
  logic wr_ok, rd_ok;
  assign bus.full = count == (ADDR_PTR_WIDTH+1)'(DEPTH);
  assign bus.empty = count == '0;
  // a write into a full FIFO is legal when a read frees a slot on the same edge
  assign wr_ok = bus.wr_en & (~bus.full | bus.rd_en);
  assign rd_ok = bus.rd_en & ~bus.empty;
`ifdef SYFIFO_COUNT_EN
  assign fill_count = count;
`endif
  always_ff @(posedge clk)
    if (wr_ok && !rst) mem[wr_ptr] <= bus.w_data;
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      bus.r_data <= '0;
      bus.wr_err <= 1'b0;
      bus.rd_err <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + ADDR_PTR_WIDTH'(wr_ok);
      rd_ptr <= rd_ptr + ADDR_PTR_WIDTH'(rd_ok);
      count <= count + (ADDR_PTR_WIDTH+1)'(wr_ok) - (ADDR_PTR_WIDTH+1)'(rd_ok);
      if (rd_ok) bus.r_data <= mem[rd_ptr];
      bus.wr_err <= bus.wr_en & bus.full & ~bus.rd_en;
      bus.rd_err <= bus.rd_en & bus.empty;
    end
endmodule

// File: tb/tb_sy_fifo.sv
// tb_sy_fifo: table vectors, directed corner sequences and random traffic checked against a queue model.
module tb_sy_fifo;
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, errors = 0;
  logic [7:0] q[$];
  logic [7:0] m_rdata;
  logic m_wr_err, m_rd_err;
  sy_fifo_if #(.WIDTH(8)) bus ();
`ifdef SYFIFO_COUNT_EN
  logic [4:0] fill_count;
  sy_fifo #(.WIDTH(8), .DEPTH(16), .ADDR_PTR_WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus), .fill_count(fill_count));
`else
  sy_fifo #(.WIDTH(8), .DEPTH(16), .ADDR_PTR_WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif
  always #5 clk = ~clk;
  typedef struct {
    logic wr, rd;
    logic [7:0] d;
    logic full, empty, wr_err, rd_err;
    logic [7:0] rdata;
  } vec_t;
  vec_t vt[9];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic check_model();
    chk("r_data", 32'(bus.r_data), 32'(m_rdata));
    chk("full", 32'(bus.full), 32'(q.size() == 16));
    chk("empty", 32'(bus.empty), 32'(q.size() == 0));
    chk("wr_err", 32'(bus.wr_err), 32'(m_wr_err));
    chk("rd_err", 32'(bus.rd_err), 32'(m_rd_err));
`ifdef SYFIFO_COUNT_EN
    chk("fill_count", 32'(fill_count), 32'(q.size()));
`endif
  endtask
  task automatic tick(input logic w, input logic r, input logic [7:0] d);
    bit f, e;
    f = q.size() == 16;
    e = q.size() == 0;
    bus.wr_en = w;
    bus.rd_en = r;
    bus.w_data = d;
    @(posedge clk);
    #1;
    m_wr_err = w & f & ~r;
    m_rd_err = r & e;
    if (r && !e) m_rdata = q.pop_front();
    if (w && (!f || r)) q.push_back(d);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    bus.w_data = 8'hFF;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    q.delete();
    m_rdata = '0;
    m_wr_err = 1'b0;
    m_rd_err = 1'b0;
    check_model();
  endtask
  initial begin
    int wl, rl, wg, rg;
    logic w, r;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.w_data = '0;
    vt[0] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00};
    vt[1] = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
    vt[2] = '{1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[3] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
    vt[4] = '{1'b1, 1'b1, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C};
    vt[5] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h7E};
    vt[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h7E};
    vt[7] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h7E};
    vt[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h7E};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      tick(vt[i].wr, vt[i].rd, vt[i].d);
      chk($sformatf("vec%0d_full", i), 32'(bus.full), 32'(vt[i].full));
      chk($sformatf("vec%0d_empty", i), 32'(bus.empty), 32'(vt[i].empty));
      chk($sformatf("vec%0d_wr_err", i), 32'(bus.wr_err), 32'(vt[i].wr_err));
      chk($sformatf("vec%0d_rd_err", i), 32'(bus.rd_err), 32'(vt[i].rd_err));
      chk($sformatf("vec%0d_r_data", i), 32'(bus.r_data), 32'(vt[i].rdata));
    end
    do_reset();
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, 1'b0, 8'($urandom));
      check_model();
    end
    chk("full_after_16", 32'(bus.full), 32'd1);
    tick(1'b1, 1'b0, 8'hEE);
    check_model();
    chk("ovf_wr_err", 32'(bus.wr_err), 32'd1);
    tick(1'b0, 1'b0, 8'h00);
    check_model();
    chk("ovf_pulse_end", 32'(bus.wr_err), 32'd0);
    tick(1'b1, 1'b1, 8'hC3);
    check_model();
    chk("full_rw_stays_full", 32'(bus.full), 32'd1);
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, 1'b1, 8'h00);
      check_model();
    end
    chk("empty_after_drain", 32'(bus.empty), 32'd1);
    chk("last_drained", 32'(bus.r_data), 32'hC3);
    do_reset();
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 1'b1, 8'h00);
      check_model();
      chk("udf_rd_err", 32'(bus.rd_err), 32'd1);
      chk("udf_r_data", 32'(bus.r_data), 32'd0);
    end
    tick(1'b1, 1'b0, 8'h5A);
    check_model();
    tick(1'b0, 1'b1, 8'h00);
    check_model();
    chk("udf_ptrs_intact", 32'(bus.r_data), 32'h5A);
    wl = 200;
    rl = 200;
    wg = 0;
    rg = 0;
    while (wl > 0 || rl > 0) begin
      w = wl > 0 && wg == 0;
      r = rl > 0 && rg == 0;
      tick(w, r, 8'($urandom));
      check_model();
      if (w) begin
        wl--;
        wg = $urandom_range(1, 5);
      end else if (wg > 0) wg--;
      if (r) begin
        rl--;
        rg = $urandom_range(1, 10);
      end else if (rg > 0) rg--;
    end
    while (q.size() > 0) begin
      tick(1'b0, 1'b1, 8'h00);
      check_model();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
